// File: rtl/fractal_zoom_sequencer.sv
// Frame-level zoom controller for fractal_generator.
// Holds the generator in reset while it computes the frame origin from the zoom centre
// and the current pitch. It then releases the generator for one frame, counts lines on
// the monitored colorized stream, and shrinks the pitch geometrically between frames.
module fractal_zoom_sequencer #(
  parameter int unsigned OUTPUT_WIDTH  = 1920,
  parameter int unsigned OUTPUT_HEIGHT = 1080,
  parameter int unsigned ZOOM_SHIFT    = 6,
  parameter int unsigned STEP_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start_in,
  input  logic                         stop_in,
  input  logic signed [31:0]           cx_in,
  input  logic signed [31:0]           cy_in,
  input  logic signed [31:0]           dx_init_in,
  input  logic signed [31:0]           dy_init_in,
  input  logic        [STEP_WIDTH-1:0] steps_in,
  input  logic                         s_tvalid,
  input  logic                         s_tready,
  input  logic                         s_tlast,
  output logic                         gen_resetn,
  output logic signed [31:0]           x0_out,
  output logic signed [31:0]           y0_out,
  output logic signed [31:0]           dx_out,
  output logic signed [31:0]           dy_out,
  output logic                         busy,
  output logic                         done,
  output logic                         frame_done,
  output logic        [STEP_WIDTH-1:0] step_count
);

  localparam int unsigned HalfW = OUTPUT_WIDTH / 2;
  localparam int unsigned HalfH = OUTPUT_HEIGHT / 2;
  localparam int unsigned LineW = (OUTPUT_HEIGHT > 2) ? $clog2(OUTPUT_HEIGHT) : 1;

  localparam logic signed [31:0] HalfWS   = 32'(HalfW);
  localparam logic signed [31:0] HalfHS   = 32'(HalfH);
  localparam logic [LineW-1:0]   LastLine = LineW'(OUTPUT_HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic                   start_q, start_d;
  logic                   armed_q, armed_d;
  logic [LineW-1:0]       line_q, line_d;
  logic signed [31:0]     cx_q, cx_d, cy_q, cy_d;
  logic signed [31:0]     dx_init_q, dx_init_d, dy_init_q, dy_init_d;
  logic [STEP_WIDTH-1:0]  steps_q, steps_d;
  logic signed [31:0]     x0_q, x0_d, y0_q, y0_d, dx_q, dx_d, dy_q, dy_d;
  logic [STEP_WIDTH-1:0]  step_count_q, step_count_d;
  logic                   gen_resetn_q, gen_resetn_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   frame_done_q, frame_done_d;

  logic                   start_edge;
  logic                   beat_last;
  logic [STEP_WIDTH-1:0]  step_inc;

  // Non-positive pitch would stall or invert the zoom; force it to the smallest step.
  function automatic logic signed [31:0] clamp_pitch(input logic signed [31:0] d);
    return (d <= 32'sd0) ? 32'sd1 : d;
  endfunction

  // One geometric zoom step, always shrinking by at least 1 and never going below 1.
  function automatic logic signed [31:0] shrink(input logic signed [31:0] d);
    logic signed [31:0] dec;
    logic signed [31:0] nd;
    dec = d >>> ZOOM_SHIFT;
    if (dec < 32'sd1) dec = 32'sd1;
    nd = d - dec;
    if (nd < 32'sd1) nd = 32'sd1;
    return nd;
  endfunction

  // armed_q requires start_in to be seen low after reset, so a start held high across a
  // reset is not mistaken for a fresh rising edge.
  assign start_edge = start_in & ~start_q & armed_q;
  assign beat_last  = s_tvalid & s_tready & s_tlast;
  assign step_inc   = step_count_q + STEP_WIDTH'(1);

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d      = state_q;
    start_d      = start_in;
    armed_d      = armed_q | ~start_in;
    line_d       = line_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    dx_init_d    = dx_init_q;
    dy_init_d    = dy_init_q;
    steps_d      = steps_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    step_count_d = step_count_q;
    frame_done_d = 1'b0;

    if (stop_in) begin
      // Abort wins over everything, including a coincident frame end.
      state_d = StIdle;
      line_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            cx_d         = cx_in;
            cy_d         = cy_in;
            dx_init_d    = clamp_pitch(dx_init_in);
            dy_init_d    = clamp_pitch(dy_init_in);
            steps_d      = steps_in;
            dx_d         = clamp_pitch(dx_init_in);
            dy_d         = clamp_pitch(dy_init_in);
            step_count_d = '0;
            line_d       = '0;
            state_d      = StCalc;
          end
        end
        StCalc: begin
          // Products and differences wrap at 32 bits by design.
          x0_d    = cx_q - (dx_q * HalfWS);
          y0_d    = cy_q - (dy_q * HalfHS);
          state_d = StRun;
        end
        StRun: begin
          if (beat_last) begin
            if (line_q == LastLine) begin
              line_d       = '0;
              frame_done_d = 1'b1;
              step_count_d = step_inc;
              if ((steps_q != '0) && (step_inc == steps_q)) begin
                state_d = StDone;
              end else begin
                if ((steps_q == '0) && (dx_q == 32'sd1) && (dy_q == 32'sd1)) begin
                  // Infinite mode bottomed out: restart the zoom from the initial pitch.
                  dx_d = dx_init_q;
                  dy_d = dy_init_q;
                end else begin
                  dx_d = shrink(dx_q);
                  dy_d = shrink(dy_q);
                end
                state_d = StCalc;
              end
            end else begin
              line_d = line_q + LineW'(1);
            end
          end
        end
        StDone: begin
          if (!start_in) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    // Outputs are registered images of the state being entered.
    gen_resetn_d = (state_d == StRun);
    busy_d       = (state_d == StCalc) || (state_d == StRun);
    done_d       = (state_d == StDone);
  end

  // State, latched sequence parameters and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      armed_q      <= 1'b0;
      line_q       <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      dx_init_q    <= '0;
      dy_init_q    <= '0;
      steps_q      <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      step_count_q <= '0;
      gen_resetn_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      armed_q      <= armed_d;
      line_q       <= line_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      dx_init_q    <= dx_init_d;
      dy_init_q    <= dy_init_d;
      steps_q      <= steps_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      step_count_q <= step_count_d;
      gen_resetn_q <= gen_resetn_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign gen_resetn = gen_resetn_q;
  assign x0_out     = x0_q;
  assign y0_out     = y0_q;
  assign dx_out     = dx_q;
  assign dy_out     = dy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_done = frame_done_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_fractal_zoom_sequencer.sv
// Directed bench for fractal_zoom_sequencer with a small 8x4 frame and shift-2 zoom.
// Expected per-frame generator parameters come from a behavioural model and are queued
// at sequence start, then popped and compared when the generator is released.
module tb_fractal_zoom_sequencer;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 4;
  localparam int unsigned SW = 16;

  logic                  clk;
  logic                  resetn;
  logic                  start_in;
  logic                  stop_in;
  logic signed [31:0]    cx_in, cy_in, dx_init_in, dy_init_in;
  logic [SW-1:0]         steps_in;
  logic                  s_tvalid, s_tready, s_tlast;
  logic                  gen_resetn;
  logic signed [31:0]    x0_out, y0_out, dx_out, dy_out;
  logic                  busy, done, frame_done;
  logic [SW-1:0]         step_count;

  typedef struct {
    logic signed [31:0] x0;
    logic signed [31:0] y0;
    logic signed [31:0] dx;
    logic signed [31:0] dy;
  } frame_t;

  frame_t exp_q[$];
  int     vectors;
  int     miscompares;

  fractal_zoom_sequencer #(
    .OUTPUT_WIDTH (W),
    .OUTPUT_HEIGHT(H),
    .ZOOM_SHIFT   (2),
    .STEP_WIDTH   (SW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start_in  (start_in),
    .stop_in   (stop_in),
    .cx_in     (cx_in),
    .cy_in     (cy_in),
    .dx_init_in(dx_init_in),
    .dy_init_in(dy_init_in),
    .steps_in  (steps_in),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .gen_resetn(gen_resetn),
    .x0_out    (x0_out),
    .y0_out    (y0_out),
    .dx_out    (dx_out),
    .dy_out    (dy_out),
    .busy      (busy),
    .done      (done),
    .frame_done(frame_done),
    .step_count(step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Pitch model: integer quarter of d, at least 1, result floored at 1.
  function automatic logic signed [31:0] m_shrink(input logic signed [31:0] d);
    logic signed [31:0] s;
    logic signed [31:0] r;
    s = d / 4;
    if (s == 0) s = 1;
    r = d - s;
    return (r < 1) ? 32'sd1 : r;
  endfunction

  task automatic push_frames(input logic signed [31:0] cx, input logic signed [31:0] cy,
                             input logic signed [31:0] dxi, input logic signed [31:0] dyi,
                             input bit inf, input int n);
    logic signed [31:0] dx, dy, dx0, dy0;
    frame_t f;
    dx0 = (dxi <= 0) ? 32'sd1 : dxi;
    dy0 = (dyi <= 0) ? 32'sd1 : dyi;
    dx  = dx0;
    dy  = dy0;
    for (int i = 0; i < n; i++) begin
      f.dx = dx;
      f.dy = dy;
      f.x0 = cx - dx * 32'sd4;
      f.y0 = cy - dy * 32'sd2;
      exp_q.push_back(f);
      if (inf && dx == 1 && dy == 1) begin
        dx = dx0;
        dy = dy0;
      end else begin
        dx = m_shrink(dx);
        dy = m_shrink(dy);
      end
    end
  endtask

  // Wait (bounded) for the generator release, then compare against the next queued frame.
  task automatic wait_run(output int cycles);
    frame_t e;
    cycles = 0;
    while (gen_resetn !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    check("run_start", gen_resetn, 1);
    check("sb_has_entry", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("x0", x0_out, e.x0);
      check("y0", y0_out, e.y0);
      check("dx", dx_out, e.dx);
      check("dy", dy_out, e.dy);
    end
  endtask

  task automatic send_line();
    s_tvalid = 1'b1;
    s_tready = 1'b1;
    s_tlast  = 1'b1;
    tick();
    s_tvalid = 1'b0;
    s_tready = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // One frame of H tlast beats; the gated variant stalls the first tlast and adds a
  // non-last beat, neither of which may count as a line.
  task automatic frame(input bit gated, input logic [SW-1:0] exp_step);
    if (gated) begin
      s_tvalid = 1'b1;
      s_tlast  = 1'b1;
      s_tready = 1'b0;
      repeat (3) tick();
      s_tready = 1'b1;
      tick();
      s_tlast = 1'b0;
      tick();
      s_tvalid = 1'b0;
      s_tready = 1'b0;
    end else begin
      send_line();
    end
    send_line();
    send_line();
    check("no_early_end", {frame_done, gen_resetn}, 2'b01);
    send_line();
    check("frame_done", frame_done, 1);
    check("gen_low_at_end", gen_resetn, 0);
    check("step_count", step_count, exp_step);
  endtask

  initial begin
    int c;
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    start_in    = 1'b0;
    stop_in     = 1'b0;
    cx_in       = '0;
    cy_in       = '0;
    dx_init_in  = '0;
    dy_init_in  = '0;
    steps_in    = '0;
    s_tvalid    = 1'b0;
    s_tready    = 1'b0;
    s_tlast     = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_outs", {gen_resetn, busy, done, frame_done}, 4'b0000);
    check("rst_x0y0", {x0_out, y0_out}, 64'h0);
    check("rst_dxdy", {dx_out, dy_out}, 64'h0);
    check("rst_step", step_count, 0);
    resetn = 1'b1;
    repeat (2) tick();
    check("idle_quiet", {gen_resetn, busy, done}, 3'b000);

    // Basic two-step sequence with handshake gating on the first frame
    cx_in      = 32'sd0;
    cy_in      = 32'sd0;
    dx_init_in = 32'sh100;
    dy_init_in = 32'sh100;
    steps_in   = 16'd2;
    push_frames(32'sd0, 32'sd0, 32'sh100, 32'sh100, 1'b0, 2);
    start_in = 1'b1;
    tick();
    check("calc_busy", {busy, gen_resetn}, 2'b10);
    check("calc_dx", dx_out, 32'sh100);
    cx_in      = 32'sh7777;
    dx_init_in = 32'sd5;
    wait_run(c);
    check("calc_len", c, 1);
    frame(1'b1, 16'd1);
    wait_run(c);
    check("gen_low_1cyc", c, 1);
    frame(1'b0, 16'd2);
    check("done_state", {done, busy}, 2'b10);
    tick();
    check("fd_pulse_1cyc", frame_done, 0);
    check("done_hold", {done, gen_resetn}, 2'b10);
    check("done_dx_hold", dx_out, 32'sh0C0);
    check("done_x0_hold", x0_out, -32'sh300);
    start_in = 1'b0;
    tick();
    check("done_exit", done, 0);

    // Clamp and wrap in infinite mode: dx 3,2,1 then reload to 3
    dx_init_in = 32'sd3;
    dy_init_in = 32'sd3;
    cx_in      = 32'sd0;
    steps_in   = 16'd0;
    push_frames(32'sd0, 32'sd0, 32'sd3, 32'sd3, 1'b1, 5);
    start_in = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      wait_run(c);
      frame(1'b0, 16'(i + 1));
      check("inf_no_done", done, 0);
    end
    stop_in = 1'b1;
    tick();
    check("stop_idle", {busy, gen_resetn}, 2'b00);
    stop_in  = 1'b0;
    start_in = 1'b0;
    tick();

    // Stop colliding with the final tlast of the second frame
    cx_in      = 32'sh10;
    cy_in      = 32'sh20;
    dx_init_in = 32'sh100;
    dy_init_in = 32'sh100;
    push_frames(32'sh10, 32'sh20, 32'sh100, 32'sh100, 1'b0, 2);
    start_in = 1'b1;
    tick();
    wait_run(c);
    frame(1'b0, 16'd1);
    wait_run(c);
    send_line();
    send_line();
    send_line();
    s_tvalid = 1'b1;
    s_tready = 1'b1;
    s_tlast  = 1'b1;
    stop_in  = 1'b1;
    tick();
    s_tvalid = 1'b0;
    s_tready = 1'b0;
    s_tlast  = 1'b0;
    stop_in  = 1'b0;
    check("coll_no_fd", frame_done, 0);
    check("coll_step", step_count, 1);
    check("coll_idle", {gen_resetn, busy}, 2'b00);
    tick();
    check("coll_still_idle", {frame_done, busy}, 2'b00);
    start_in = 1'b0;
    tick();

    // Asynchronous reset in the middle of a frame, start held high across it
    cx_in = 32'sd0;
    cy_in = 32'sd0;
    push_frames(32'sd0, 32'sd0, 32'sh100, 32'sh100, 1'b0, 1);
    start_in = 1'b1;
    tick();
    wait_run(c);
    send_line();
    send_line();
    #2 resetn = 1'b0;
    #1;
    check("async_ctl", {gen_resetn, busy, done, frame_done}, 4'b0000);
    check("async_params", {x0_out, dx_out}, 64'h0);
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    check("no_restart", {busy, gen_resetn}, 2'b00);
    start_in = 1'b0;
    tick();
    push_frames(32'sd0, 32'sd0, 32'sh100, 32'sh100, 1'b0, 1);
    start_in = 1'b1;
    tick();
    check("restart_busy", busy, 1);
    wait_run(c);
    frame(1'b0, 16'd1);
    stop_in = 1'b1;
    tick();
    stop_in  = 1'b0;
    start_in = 1'b0;
    tick();

    // Non-positive initial pitch is loaded as 1
    cx_in      = 32'sh1000;
    cy_in      = 32'sh2000;
    dx_init_in = 32'sd0;
    dy_init_in = -32'sd5;
    steps_in   = 16'd1;
    push_frames(32'sh1000, 32'sh2000, 32'sd0, -32'sd5, 1'b0, 1);
    start_in = 1'b1;
    tick();
    wait_run(c);
    frame(1'b0, 16'd1);
    check("bad_done", done, 1);
    start_in = 1'b0;
    tick();

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
